// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its neighbours.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_WIDTH     = 5;
    localparam int DIV_CYCLES_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        DIV_DONE = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hz_load_use_cmp.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX is about to write.
module hz_load_use_cmp #(
    parameter int RegAddrWidth = 5
) (
    input  logic [RegAddrWidth-1:0] raddr_1,
    input  logic [RegAddrWidth-1:0] raddr_2,
    input  logic                    use_rs,
    input  logic                    use_rt,
    input  logic                    read_mem,
    input  logic                    write_reg,
    input  logic [RegAddrWidth-1:0] waddr,
    output logic                    lu_hit
);

    // $zero is never a real dependency, so a write to it never stalls
    always_comb begin
        lu_hit = read_mem && write_reg && (waddr != '0) &&
                 ((use_rs && (raddr_1 == waddr)) || (use_rt && (raddr_2 == waddr)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal flow; a divide entering EX starts the countdown
// DIV_WAIT | divide occupying EX, cnt counts the remaining stall cycles
// DIV_DONE | divide leaving EX; its div_start_EX is ignored
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RegAddrWidth = REG_ADDR_WIDTH,
    parameter int DIV_CYCLES   = DIV_CYCLES_DEFAULT,
    parameter int CNT_W        = $clog2(DIV_CYCLES),
    parameter int STALL_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RegAddrWidth-1:0] raddr_1_ID,
    input  logic [RegAddrWidth-1:0] raddr_2_ID,
    input  logic                    use_rs_ID,
    input  logic                    use_rt_ID,
    input  logic                    ReadMem_EX,
    input  logic                    WriteReg_EX,
    input  logic [RegAddrWidth-1:0] waddr_EX,
    input  logic                    div_start_EX,
    input  logic                    branch_taken_ID,
    input  logic                    mem_req_MEM,
    input  logic                    mem_ready_MEM,
    output logic                    hold_pc,
    output logic                    hold_IF_ID,
    output logic                    hold_ID_EX,
    output logic                    hold_EX_MEM,
    output logic                    flush_IF_ID,
    output logic                    flush_ID_EX,
    output logic                    flush_EX_MEM,
    output logic                    flush_MEM_WB,
    output logic                    div_busy,
    output logic [STALL_CNT_W-1:0]  stall_cycles
);

    hz_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lu_hit;
    logic             mem_stall;

    hz_load_use_cmp #(.RegAddrWidth(RegAddrWidth)) u_lu_cmp (
        .raddr_1   (raddr_1_ID),
        .raddr_2   (raddr_2_ID),
        .use_rs    (use_rs_ID),
        .use_rt    (use_rt_ID),
        .read_mem  (ReadMem_EX),
        .write_reg (WriteReg_EX),
        .waddr     (waddr_EX),
        .lu_hit    (lu_hit)
    );

    assign mem_stall = mem_req_MEM && !mem_ready_MEM;

    // State, divide countdown and stall statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (hold_pc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
        end
    end

    // Next state plus prioritised hold/flush decode; everything is quiet while in reset
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        hold_pc      = 1'b0;
        hold_IF_ID   = 1'b0;
        hold_ID_EX   = 1'b0;
        hold_EX_MEM  = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        div_busy     = 1'b0;

        if (rst) begin
            unique case (state)
                RUN: begin
                    if (div_start_EX && !mem_stall) begin
                        state_next = DIV_WAIT;
                        cnt_next   = CNT_W'(DIV_CYCLES - 1);
                        div_busy   = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    // The divider keeps running even while memory stalls the pipe
                    cnt_next = cnt - CNT_W'(1);
                    div_busy = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_next = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!mem_stall) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase

            if (mem_stall) begin
                hold_pc      = 1'b1;
                hold_IF_ID   = 1'b1;
                hold_ID_EX   = 1'b1;
                hold_EX_MEM  = 1'b1;
                flush_MEM_WB = 1'b1;
            end else if ((state == DIV_WAIT) || ((state == RUN) && div_start_EX)) begin
                hold_pc      = 1'b1;
                hold_IF_ID   = 1'b1;
                hold_ID_EX   = 1'b1;
                flush_EX_MEM = 1'b1;
            end else if (lu_hit) begin
                hold_pc      = 1'b1;
                hold_IF_ID   = 1'b1;
                flush_ID_EX  = 1'b1;
            end

            // A stalled branch stays in ID and is re-evaluated next cycle
            flush_IF_ID = branch_taken_ID && !hold_IF_ID;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int DC = 4;
    localparam int SW = 4;
    localparam int SAT = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] raddr_1_ID, raddr_2_ID, waddr_EX;
    logic          use_rs_ID, use_rt_ID, ReadMem_EX, WriteReg_EX;
    logic          div_start_EX, branch_taken_ID, mem_req_MEM, mem_ready_MEM;
    logic          hold_pc, hold_IF_ID, hold_ID_EX, hold_EX_MEM;
    logic          flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, div_busy;
    logic [SW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Model: remaining divide wait cycles, pending "divide leaving EX" cycle, stall count
    int div_left     = 0;
    bit done_pending = 1'b0;
    int stall_model  = 0;

    pipe_hazard_ctrl #(
        .RegAddrWidth (AW),
        .DIV_CYCLES   (DC),
        .STALL_CNT_W  (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .raddr_1_ID      (raddr_1_ID),
        .raddr_2_ID      (raddr_2_ID),
        .use_rs_ID       (use_rs_ID),
        .use_rt_ID       (use_rt_ID),
        .ReadMem_EX      (ReadMem_EX),
        .WriteReg_EX     (WriteReg_EX),
        .waddr_EX        (waddr_EX),
        .div_start_EX    (div_start_EX),
        .branch_taken_ID (branch_taken_ID),
        .mem_req_MEM     (mem_req_MEM),
        .mem_ready_MEM   (mem_ready_MEM),
        .hold_pc         (hold_pc),
        .hold_IF_ID      (hold_IF_ID),
        .hold_ID_EX      (hold_ID_EX),
        .hold_EX_MEM     (hold_EX_MEM),
        .flush_IF_ID     (flush_IF_ID),
        .flush_ID_EX     (flush_ID_EX),
        .flush_EX_MEM    (flush_EX_MEM),
        .flush_MEM_WB    (flush_MEM_WB),
        .div_busy        (div_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {hold_pc, hold_IF_ID, hold_ID_EX, hold_EX_MEM,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB, div_busy};
    endfunction

    task automatic drive(input int ra1, input int ra2, input bit urs, input bit urt,
                         input bit rm, input bit wr, input int wa, input bit ds,
                         input bit br, input bit mq, input bit mr);
        raddr_1_ID      = AW'(ra1);
        raddr_2_ID      = AW'(ra2);
        use_rs_ID       = urs;
        use_rt_ID       = urt;
        ReadMem_EX      = rm;
        WriteReg_EX     = wr;
        waddr_EX        = AW'(wa);
        div_start_EX    = ds;
        branch_taken_ID = br;
        mem_req_MEM     = mq;
        mem_ready_MEM   = mr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic model_reset();
        div_left     = 0;
        done_pending = 1'b0;
        stall_model  = 0;
    endtask

    // Check this cycle's outputs against the rules, then advance one clock.
    task automatic step(input string tag);
        bit mem, lu, in_run, div_stall;
        bit hpc, hif, hid, hem, fif, fid, fem, fwb, busy;
        #1;
        in_run    = (div_left == 0) && !done_pending;
        mem       = mem_req_MEM && !mem_ready_MEM;
        lu        = ReadMem_EX && WriteReg_EX && (waddr_EX != 0) &&
                    ((use_rs_ID && raddr_1_ID == waddr_EX) || (use_rt_ID && raddr_2_ID == waddr_EX));
        div_stall = (div_left > 0) || (in_run && div_start_EX);
        {hpc, hif, hid, hem, fif, fid, fem, fwb} = '0;
        if (mem) {hpc, hif, hid, hem, fwb} = '1;
        else if (div_stall) {hpc, hif, hid, fem} = '1;
        else if (lu) {hpc, hif, fid} = '1;
        fif  = branch_taken_ID && !hif;
        busy = (div_left > 0) || (in_run && div_start_EX && !mem);
        check({tag, ".outs"}, 32'(dut_vec()), 32'({hpc, hif, hid, hem, fif, fid, fem, fwb, busy}));
        check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(stall_model));

        if (hpc && stall_model < SAT) stall_model++;
        if (div_left > 0) begin
            div_left--;
            if (div_left == 0) done_pending = 1'b1;
        end else if (done_pending) begin
            if (!mem) done_pending = 1'b0;
        end else if (div_start_EX && !mem) begin
            div_left = DC - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst.outs", 32'(dut_vec()), 32'(0));
        check("rst.stall_cycles", 32'(stall_cycles), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        idle();
        #1;
        check("por.outs", 32'(dut_vec()), 32'(0));
        check("por.stall_cycles", 32'(stall_cycles), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Load-use: one bubble, then none once the load has moved on; $zero never stalls
        drive(8, 3, 1, 0, 1, 1, 8, 0, 0, 0, 1);
        #1;
        check("lu.hold_pc", 32'(hold_pc), 32'(1));
        check("lu.flush_ID_EX", 32'(flush_ID_EX), 32'(1));
        step("lu_hit");
        idle();
        step("lu_after");
        drive(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1);
        #1;
        check("lu_zero.hold_pc", 32'(hold_pc), 32'(0));
        step("lu_zero");

        // Divide with div_start held five cycles: four stalls, then a quiet DIV_DONE
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
            #1;
            check($sformatf("div.c%0d.flush_EX_MEM", i), 32'(flush_EX_MEM), 32'(i < 4));
            step($sformatf("div.c%0d", i));
        end
        idle();
        check("div.stall_cycles", 32'(stall_cycles), 32'(4));
        step("div_end");

        // Memory wait while the divide is leaving EX keeps DIV_DONE for three cycles
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step($sformatf("div2.c%0d", i));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            #1;
            check($sformatf("memdone.c%0d.flush_MEM_WB", i), 32'(flush_MEM_WB), 32'(1));
            step($sformatf("memdone.c%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("memdone.release");
        // Back in RUN: a new divide start stalls again
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        #1;
        check("memdone.run_restart", 32'(div_busy), 32'(1));
        step("memdone.restart");
        idle();
        for (int i = 0; i < 4; i++) step($sformatf("drain.c%0d", i));

        // Branch coinciding with a load-use stall is deferred one cycle
        drive(5, 0, 1, 0, 1, 1, 5, 0, 1, 0, 1);
        #1;
        check("br_stall.flush_IF_ID", 32'(flush_IF_ID), 32'(0));
        step("br_stall");
        drive(5, 0, 1, 0, 0, 0, 5, 0, 1, 0, 1);
        #1;
        check("br_free.flush_IF_ID", 32'(flush_IF_ID), 32'(1));
        step("br_free");

        // Reset in DIV_WAIT with cnt=2 abandons the divide
        apply_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("rdiv.start");
        idle();
        step("rdiv.wait");
        drive(9, 0, 1, 0, 1, 1, 9, 0, 1, 1, 0);
        rst = 1'b0;
        #1;
        check("rdiv.outs", 32'(dut_vec()), 32'(0));
        check("rdiv.stall_cycles", 32'(stall_cycles), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(9, 0, 1, 0, 1, 1, 9, 0, 0, 0, 1);
        #1;
        check("rdiv.post.hold_ID_EX", 32'(hold_ID_EX), 32'(0));
        check("rdiv.post.flush_ID_EX", 32'(flush_ID_EX), 32'(1));
        step("rdiv.post");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0));
            step($sformatf("rnd%0d", i));
        end

        // Saturation: twenty memory wait cycles pin the counter at all-ones
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step($sformatf("sat.c%0d", i));
        end
        idle();
        check("sat.final", 32'(stall_cycles), 32'(SAT));
        step("sat.hold");
        check("sat.stays", 32'(stall_cycles), 32'(SAT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
